// File: rtl/fft_seq_pkg.sv
// Shared types for the FFT frame sequencer: FSM state encoding and frame counter width.
package fft_seq_pkg;
  typedef enum logic [1:0] {FILL, SETTLE, CAPTURE, DRAIN} seq_state_t;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample-in / bin-out stream handshakes of the FFT frame sequencer.
interface fft_frame_sequencer_if #(parameter int sample_size = 32);
  logic [sample_size-1:0] s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [sample_size-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;

  // master: sample source + bin consumer; slave: the sequencer
  modport master (output s_data, s_valid, m_ready, input s_ready, m_data, m_valid, m_last);
  modport slave  (input s_data, s_valid, m_ready, output s_ready, m_data, m_valid, m_last);
endinterface

// File: rtl/frame_slot_counter.sv
// Modulo-n slot index with enable and clear; wrap flags the enabled step off slot n-1.
module frame_slot_counter #(
  parameter  int n = 8,
  localparam int w = $clog2(n)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [w-1:0] idx,
  output logic         wrap
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      idx <= '0;
    else if (clr) idx <= '0;
    else if (en)  idx <= idx + 1'b1;   // n is a power of two, so this wraps to 0
  end

  assign wrap = en && (idx == w'(n - 1));
endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a sample stream into the combinational FFT, waits settle_cycles, then streams bins out.
// Optional: define FFT_SEQ_FRAME_CNT_EN to add a 16-bit completed-frame counter port.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int sample_size   = 32,
  parameter int buffer_size   = 8,
  parameter int settle_cycles = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  fft_frame_sequencer_if.slave               bus,
  output logic [sample_size*buffer_size-1:0] fft_in_bus,
  input  logic [sample_size*buffer_size-1:0] fft_out_bus,
  output logic                               busy
`ifdef FFT_SEQ_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0]             frame_cnt
`endif
);
  localparam int IW = $clog2(buffer_size);
  localparam int SW = $clog2(settle_cycles + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(settle_cycles - 1);
  localparam logic [IW-1:0] SLOT_LAST   = IW'(buffer_size - 1);

  seq_state_t state, state_nxt;
  logic [buffer_size-1:0][sample_size-1:0] in_frame, out_frame;
  logic [SW-1:0] settle_cnt;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_en, wr_wrap, rd_en, rd_clr, rd_wrap;

  assign wr_en  = (state == FILL) && bus.s_valid;
  assign rd_en  = (state == DRAIN) && bus.m_ready;
  assign rd_clr = (state == CAPTURE);

  frame_slot_counter #(.n(buffer_size)) u_wr_cnt (
    .clk(clk), .rst(rst), .en(wr_en), .clr(1'b0), .idx(wr_idx), .wrap(wr_wrap)
  );

  frame_slot_counter #(.n(buffer_size)) u_rd_cnt (
    .clk(clk), .rst(rst), .en(rd_en), .clr(rd_clr), .idx(rd_idx), .wrap(rd_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (wr_wrap) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   if (rd_wrap) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Input frame only changes in FILL, so the FFT sees a frozen bus across SETTLE/CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame   <= '0;
      out_frame  <= '0;
      settle_cnt <= '0;
    end else begin
      if (wr_en)             in_frame[wr_idx] <= bus.s_data;
      if (state == CAPTURE)  out_frame <= fft_out_bus;
      if (state == SETTLE)   settle_cnt <= settle_cnt + 1'b1;
      else                   settle_cnt <= '0;
    end
  end

  assign fft_in_bus  = in_frame;
  assign bus.s_ready = (state == FILL);
  assign bus.m_valid = (state == DRAIN);
  assign bus.m_data  = out_frame[rd_idx];
  assign bus.m_last  = (state == DRAIN) && (rd_idx == SLOT_LAST);
  assign busy        = (state != FILL);

`ifdef FFT_SEQ_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_cnt <= '0;
    else if (rd_wrap) frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule
